// File: rtl/axis_width_pkg.sv
// Shared types and constant helpers for the AXI-Stream width converters
// (slim-to-wide combiner and wide-to-slim splitter).
package axis_width_pkg;

   localparam int MAX_KEEP   = 128;
   localparam int KEEP_IDX_W = $clog2(MAX_KEEP);

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } buf_state_t;

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // Keep is only meaningful when both sides split cleanly on byte lanes.
   function automatic bit keep_enable(input int wideDsize, input int slimDsize);
      return is_pow2(wideDsize) && is_pow2(slimDsize) &&
             (wideDsize % 8 == 0) && (slimDsize % 8 == 0) && (slimDsize >= 8);
   endfunction

   // Highest MSB-first slice index holding any keep bit; 0 when keep is empty.
   function automatic int last_keep_slice(input logic [MAX_KEEP-1:0] keep,
                                          input int nsize, input int sksize);
      int lastIdx;
      lastIdx = 0;
      for (int i = 0; i < nsize; i++) begin
         for (int j = 0; j < sksize; j++) begin
            if (keep[KEEP_IDX_W'(nsize * sksize - 1 - i * sksize - j)]) begin
               lastIdx = i;
            end
         end
      end
      return lastIdx;
   endfunction

endpackage

// File: rtl/axis_width_destruct_a1.sv
// Wide-to-slim AXI-Stream splitter: each wide beat leaves as NSIZE slim beats, MSB slice
// first, with empty trailing slices trimmed from a packet's final beat.
module axis_width_destruct_a1
   import axis_width_pkg::*;
#(
   parameter  int WIDE_DSIZE = 32,
   parameter  int SLIM_DSIZE = 8,
   localparam int NSIZE      = WIDE_DSIZE / SLIM_DSIZE,
   localparam int WKSIZE     = WIDE_DSIZE / 8,
   localparam int SKSIZE     = SLIM_DSIZE / 8
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [WIDE_DSIZE-1:0] i_wide_tdata,
   input  logic [WKSIZE-1:0]     i_wide_tkeep,
   input  logic                  i_wide_tvalid,
   output logic                  o_wide_tready,
   input  logic                  i_wide_tlast,
   input  logic                  i_wide_tuser,
   output logic [SLIM_DSIZE-1:0] o_slim_tdata,
   output logic [SKSIZE-1:0]     o_slim_tkeep,
   output logic                  o_slim_tvalid,
   input  logic                  i_slim_tready,
   output logic                  o_slim_tlast,
   output logic                  o_slim_tuser
);

   localparam int PW      = $clog2(NSIZE);
   localparam bit KEEP_EN = keep_enable(WIDE_DSIZE, SLIM_DSIZE);

   if (WIDE_DSIZE != NSIZE * SLIM_DSIZE) begin : g_badWidth
      $error("WIDE_DSIZE (%0d) must be a multiple of SLIM_DSIZE (%0d)", WIDE_DSIZE, SLIM_DSIZE);
   end
   if (NSIZE < 2) begin : g_badRatio
      $error("WIDE_DSIZE/SLIM_DSIZE must be at least 2");
   end

   buf_state_t              r_state;
   buf_state_t              w_nextState;
   logic [WIDE_DSIZE-1:0]   r_bufData;
   logic [WKSIZE-1:0]       r_bufKeep;
   logic                    r_bufLast;
   logic                    r_bufUser;
   logic [PW-1:0]           r_point;
   logic [PW-1:0]           r_endPoint;

   logic                    w_bufVld;
   logic                    w_slimFire;
   logic                    w_sliceDone;
   logic                    w_load;
   logic [PW-1:0]           w_loadEnd;
   logic [SLIM_DSIZE-1:0]   w_dataSlice [NSIZE];
   logic [SKSIZE-1:0]       w_keepSlice [NSIZE];

   assign w_bufVld    = (r_state == SEND);
   assign w_slimFire  = w_bufVld && i_slim_tready;
   assign w_sliceDone = w_slimFire && (r_point == r_endPoint);
   assign w_load      = i_wide_tvalid && o_wide_tready;

   // Accepting while the final slice drains keeps the slim side free of bubbles.
   assign o_wide_tready = !w_bufVld || w_sliceDone;

   always_comb begin
      w_loadEnd = PW'(NSIZE - 1);
      if (KEEP_EN && i_wide_tlast) begin
         w_loadEnd = PW'(last_keep_slice(MAX_KEEP'(i_wide_tkeep), NSIZE, SKSIZE));
      end
   end

   for (genvar i = 0; i < NSIZE; i++) begin : g_slice
      assign w_dataSlice[i] = r_bufData[WIDE_DSIZE-1-i*SLIM_DSIZE -: SLIM_DSIZE];
      assign w_keepSlice[i] = r_bufKeep[WKSIZE-1-i*SKSIZE -: SKSIZE];
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (w_load) begin
         w_nextState = SEND;
      end else if (w_sliceDone) begin
         w_nextState = EMPTY;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_bufData <= '0;
         r_bufKeep <= '0;
         r_bufLast <= 1'b0;
         r_bufUser <= 1'b0;
      end else if (w_load) begin
         r_bufData <= i_wide_tdata;
         r_bufKeep <= i_wide_tkeep;
         r_bufLast <= i_wide_tlast;
         r_bufUser <= i_wide_tuser;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_point    <= '0;
         r_endPoint <= '0;
      end else if (w_load) begin
         r_point    <= '0;
         r_endPoint <= w_loadEnd;
      end else if (w_sliceDone) begin
         r_point    <= '0;
      end else if (w_slimFire) begin
         r_point    <= r_point + PW'(1);
      end
   end

   assign o_slim_tvalid = w_bufVld;
   assign o_slim_tdata  = w_dataSlice[r_point];
   assign o_slim_tlast  = w_bufVld && r_bufLast && (r_point == r_endPoint);
   assign o_slim_tuser  = r_bufUser;

   // Without usable keep lanes every emitted slice is reported fully populated.
   if (KEEP_EN) begin : g_keepOn
      assign o_slim_tkeep = w_keepSlice[r_point];
   end else begin : g_keepOff
      assign o_slim_tkeep = {SKSIZE{w_bufVld}};
   end

endmodule

// File: tb/tb_axis_width_destruct_a1.sv
// Scoreboard bench for the 32-to-8 AXI-Stream splitter: the wide-beat model pushes
// expected slim beats, a negedge monitor collects real ones, each test compares them.
module tb_axis_width_destruct_a1;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       last;
      logic       user;
   } beat_t;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_wide_tdata = '0;
   logic [3:0]  i_wide_tkeep = '0;
   logic        i_wide_tvalid = 1'b0;
   logic        o_wide_tready;
   logic        i_wide_tlast = 1'b0;
   logic        i_wide_tuser = 1'b0;
   logic [7:0]  o_slim_tdata;
   logic [0:0]  o_slim_tkeep;
   logic        o_slim_tvalid;
   logic        i_slim_tready = 1'b1;
   logic        o_slim_tlast;
   logic        o_slim_tuser;

   beat_t expQ[$];
   beat_t obsQ[$];
   int    obsCyc[$];
   int    testsRun = 0;
   int    testsFailed = 0;
   int    cycle = 0;
   int    lastWideCyc = 0;
   int    stallViol = 0;
   bit    randDone = 0;
   logic        stallPrev = 1'b0;
   logic [7:0]  stallData;
   logic        stallLast;
   logic        stallKeep;

   axis_width_destruct_a1 #(.WIDE_DSIZE(32), .SLIM_DSIZE(8)) dut (
      .clock         (clock),
      .rst_n         (rst_n),
      .i_wide_tdata  (i_wide_tdata),
      .i_wide_tkeep  (i_wide_tkeep),
      .i_wide_tvalid (i_wide_tvalid),
      .o_wide_tready (o_wide_tready),
      .i_wide_tlast  (i_wide_tlast),
      .i_wide_tuser  (i_wide_tuser),
      .o_slim_tdata  (o_slim_tdata),
      .o_slim_tkeep  (o_slim_tkeep),
      .o_slim_tvalid (o_slim_tvalid),
      .i_slim_tready (i_slim_tready),
      .o_slim_tlast  (o_slim_tlast),
      .o_slim_tuser  (o_slim_tuser)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Collect every slim handshake and flag any output change while stalled.
   always @(negedge clock) begin
      if (rst_n && o_slim_tvalid && i_slim_tready) begin
         obsQ.push_back({o_slim_tdata, o_slim_tkeep[0], o_slim_tlast, o_slim_tuser});
         obsCyc.push_back(cycle);
      end
      if (rst_n && stallPrev) begin
         if (o_slim_tvalid !== 1'b1 || o_slim_tdata !== stallData ||
             o_slim_tlast !== stallLast || o_slim_tkeep[0] !== stallKeep) begin
            stallViol++;
         end
      end
      stallPrev = rst_n && o_slim_tvalid && !i_slim_tready;
      stallData = o_slim_tdata;
      stallLast = o_slim_tlast;
      stallKeep = o_slim_tkeep[0];
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void pushExpected(input logic [31:0] d, input logic [3:0] k,
                                        input logic l, input logic u);
      int    n;
      int    e;
      beat_t b;
      e = 0;
      for (int i = 0; i < 4; i++) if (k[3-i]) e = i;
      n = l ? e + 1 : 4;
      for (int i = 0; i < n; i++) begin
         b.data = d[31-8*i -: 8];
         b.keep = k[3-i];
         b.last = l && (i == n - 1);
         b.user = u;
         expQ.push_back(b);
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the wide handshake.
   task automatic sendWide(input logic [31:0] d, input logic [3:0] k,
                           input logic l, input logic u);
      int guard;
      guard = 0;
      i_wide_tdata  = d;
      i_wide_tkeep  = k;
      i_wide_tlast  = l;
      i_wide_tuser  = u;
      i_wide_tvalid = 1'b1;
      pushExpected(d, k, l, u);
      @(negedge clock);
      while (!o_wide_tready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (!o_wide_tready) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL wide_handshake: wide_tready=%b after %0d cycles, want 1", o_wide_tready, guard);
      end
      lastWideCyc = cycle;
      @(posedge clock);
      #1;
      i_wide_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_slim_tready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      testsRun++;
      if ({o_slim_tvalid, o_slim_tlast, o_slim_tuser, o_slim_tdata, o_slim_tkeep, o_wide_tready}
          !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got v=%b l=%b u=%b d=%h k=%b wr=%b, want 0 0 0 00 0 1",
                  o_slim_tvalid, o_slim_tlast, o_slim_tuser, o_slim_tdata, o_slim_tkeep, o_wide_tready);
      end
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(negedge clock);
      testsRun++;
      if (o_slim_tvalid !== 1'b0 || o_wide_tready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_release: got v=%b wr=%b, want 0 1", o_slim_tvalid, o_wide_tready);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_beat();
      logic [3:0] readyLog;
      beat_t wantB, gotB;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      i_slim_tready = 1'b1;
      sendWide(32'hAABBCCDD, 4'hF, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         readyLog[k] = o_wide_tready;
      end
      @(negedge clock);
      testsRun++;
      if (o_slim_tvalid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_idle: slim_tvalid=%b after last slice, want 0", o_slim_tvalid);
      end
      testsRun++;
      if (readyLog !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL single_wide_tready: got %b per slice (LSB first), want 1000", readyLog);
      end
      testsRun++;
      if (obsCyc.size() < 1 || obsCyc[0] !== lastWideCyc + 1) begin
         testsFailed++;
         $display("[TB] FAIL single_latency: first slim at cycle %0d, want %0d",
                  (obsCyc.size() > 0) ? obsCyc[0] : -1, lastWideCyc + 1);
      end
      testsRun++;
      if (obsQ.size() !== expQ.size()) begin
         testsFailed++;
         $display("[TB] FAIL single_count: got %0d beats, want %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL single_beat: got %h want %h", gotB, wantB);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_back_to_back();
      bit gap;
      beat_t wantB, gotB;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      i_slim_tready = 1'b1;
      sendWide(32'h01020304, 4'hF, 1'b0, 1'b1);
      sendWide(32'h05060708, 4'hF, 1'b1, 1'b1);
      for (int g = 0; g < 50 && obsQ.size() < expQ.size(); g++) @(posedge clock);
      #1;
      gap = 0;
      for (int i = 0; i < obsCyc.size(); i++) if (obsCyc[i] !== obsCyc[0] + i) gap = 1;
      testsRun++;
      if (gap || obsQ.size() !== 8) begin
         testsFailed++;
         $display("[TB] FAIL b2b_contiguous: got %0d beats gap=%0d, want 8 beats gap=0", obsQ.size(), gap);
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL b2b_beat: got %h want %h", gotB, wantB);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_trim();
      int drainCyc;
      beat_t wantB, gotB;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      i_slim_tready = 1'b1;
      sendWide(32'h11223300, 4'hE, 1'b1, 1'b0);
      sendWide(32'h44556677, 4'hF, 1'b1, 1'b0);
      for (int g = 0; g < 50 && obsQ.size() < expQ.size(); g++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      drainCyc = (obsCyc.size() > 2) ? obsCyc[2] : -1;
      testsRun++;
      if (drainCyc !== lastWideCyc) begin
         testsFailed++;
         $display("[TB] FAIL trim_reload: next beat accepted at cycle %0d, want %0d (slice 33 drain)",
                  lastWideCyc, drainCyc);
      end
      testsRun++;
      if (obsQ.size() !== 7) begin
         testsFailed++;
         $display("[TB] FAIL trim_count: got %0d beats, want 7", obsQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL trim_beat: got %h want %h", gotB, wantB);
         end
      end
   endtask

   task automatic test_zero_keep();
      beat_t wantB, gotB;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      i_slim_tready = 1'b1;
      sendWide(32'hDEADBEEF, 4'h0, 1'b1, 1'b1);
      repeat (6) @(posedge clock);
      #1;
      testsRun++;
      if (obsQ.size() !== 1) begin
         testsFailed++;
         $display("[TB] FAIL zero_keep_count: got %0d beats, want 1", obsQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL zero_keep_beat: got %h want %h", gotB, wantB);
         end
      end
   endtask

   task automatic test_random_ready();
      beat_t wantB, gotB;
      int    nb;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      stallViol = 0;
      randDone  = 0;
      fork
         begin
            while (!randDone) begin
               @(posedge clock);
               #1;
               i_slim_tready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int p = 0; p < 100; p++) begin
               nb = $urandom_range(1, 3);
               for (int b = 0; b < nb; b++) begin
                  sendWide($urandom, 4'($urandom_range(0, 15)), b == nb - 1, 1'($urandom_range(0, 1)));
                  if ($urandom_range(0, 3) == 0) begin
                     @(posedge clock);
                     #1;
                  end
               end
            end
            for (int g = 0; g < 5000 && obsQ.size() < expQ.size(); g++) @(posedge clock);
            randDone = 1;
         end
      join
      i_slim_tready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      testsRun++;
      if (stallViol !== 0) begin
         testsFailed++;
         $display("[TB] FAIL random_stall_stable: %0d output changes during stalls, want 0", stallViol);
      end
      testsRun++;
      if (obsQ.size() !== expQ.size()) begin
         testsFailed++;
         $display("[TB] FAIL random_count: got %0d beats, want %0d", obsQ.size(), expQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL random_beat: got %h want %h", gotB, wantB);
         end
      end
   endtask

   task automatic test_mid_reset();
      beat_t wantB, gotB;
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      i_slim_tready = 1'b1;
      sendWide(32'hA1B2C3D4, 4'hF, 1'b1, 1'b0);
      @(negedge clock);
      @(negedge clock);
      @(posedge clock);
      #1;
      rst_n = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(negedge clock);
      testsRun++;
      if (o_slim_tvalid !== 1'b0 || o_wide_tready !== 1'b1 || o_slim_tlast !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_state: got v=%b wr=%b l=%b, want 0 1 0",
                  o_slim_tvalid, o_wide_tready, o_slim_tlast);
      end
      testsRun++;
      if (obsQ.size() !== 2) begin
         testsFailed++;
         $display("[TB] FAIL midreset_before: got %0d beats before reset, want 2", obsQ.size());
      end
      for (int i = 0; i < 2 && obsQ.size() > 0; i++) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL midreset_prefix: got %h want %h", gotB, wantB);
         end
      end
      expQ.delete(); obsQ.delete(); obsCyc.delete();
      @(posedge clock);
      #1;
      sendWide(32'h0F1E2D3C, 4'hF, 1'b1, 1'b1);
      for (int g = 0; g < 50 && obsQ.size() < expQ.size(); g++) @(posedge clock);
      repeat (2) @(posedge clock);
      #1;
      testsRun++;
      if (obsQ.size() !== 4) begin
         testsFailed++;
         $display("[TB] FAIL midreset_after_count: got %0d beats, want 4", obsQ.size());
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         wantB = expQ.pop_front();
         gotB  = obsQ.pop_front();
         testsRun++;
         if (gotB !== wantB) begin
            testsFailed++;
            $display("[TB] FAIL midreset_after: got %h want %h", gotB, wantB);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_trim();
      test_zero_keep();
      test_random_ready();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
